// File: rtl/fpu_shift_arb.sv
// Shared barrel-shifter arbiter: two FPU stages take turns on one bsr/bsl
// pair, with a registered valid/ready response carrying result, sticky and ID.

module bsr #(
   parameter int WIDTH  = 32,
   parameter int SWIDTH = 5
) (
   input  logic [WIDTH-1:0]  din,
   input  logic [SWIDTH-1:0] s,
   input  logic              filler,
   output logic [WIDTH-1:0]  dout,
   output logic              sticky
);
   localparam logic [SWIDTH:0] WLIM = WIDTH[SWIDTH:0];

   logic [WIDTH-1:0] stg [0:SWIDTH];
   logic             stk [0:SWIDTH];
   logic             ovf;

   assign stg[0] = din;
   assign stk[0] = 1'b0;
   assign ovf    = ({1'b0, s} >= WLIM);

   // Stages at or beyond WIDTH are folded into ovf, so filler never reaches
   // the low end of a stage and shifted-out bits are always operand bits.
   for (genvar k = 0; k < SWIDTH; k++) begin : g_stage
      localparam int AMT = 1 << k;
      if (AMT < WIDTH) begin : g_live
         assign stg[k+1] = s[k] ? {{AMT{filler}}, stg[k][WIDTH-1:AMT]} : stg[k];
         assign stk[k+1] = stk[k] | (s[k] & (|stg[k][AMT-1:0]));
      end else begin : g_pass
         assign stg[k+1] = stg[k];
         assign stk[k+1] = stk[k];
      end
   end

   assign dout   = ovf ? {WIDTH{filler}} : stg[SWIDTH];
   assign sticky = ovf ? (|din) : stk[SWIDTH];
endmodule

module bsl #(
   parameter int WIDTH  = 32,
   parameter int SWIDTH = 5
) (
   input  logic [WIDTH-1:0]  din,
   input  logic [SWIDTH-1:0] s,
   input  logic              filler,
   output logic [WIDTH-1:0]  dout,
   output logic              sticky
);
   localparam logic [SWIDTH:0] WLIM = WIDTH[SWIDTH:0];

   logic [WIDTH-1:0] stg [0:SWIDTH];
   logic             stk [0:SWIDTH];
   logic             ovf;

   assign stg[0] = din;
   assign stk[0] = 1'b0;
   assign ovf    = ({1'b0, s} >= WLIM);

   for (genvar k = 0; k < SWIDTH; k++) begin : g_stage
      localparam int AMT = 1 << k;
      if (AMT < WIDTH) begin : g_live
         assign stg[k+1] = s[k] ? {stg[k][WIDTH-AMT-1:0], {AMT{filler}}} : stg[k];
         assign stk[k+1] = stk[k] | (s[k] & (|stg[k][WIDTH-1:WIDTH-AMT]));
      end else begin : g_pass
         assign stg[k+1] = stg[k];
         assign stk[k+1] = stk[k];
      end
   end

   assign dout   = ovf ? {WIDTH{filler}} : stg[SWIDTH];
   assign sticky = ovf ? (|din) : stk[SWIDTH];
endmodule

module fpu_shift_arb #(
   parameter int WIDTH  = 32,
   parameter int SWIDTH = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [WIDTH-1:0]  req0_din,
   input  logic [SWIDTH-1:0] req0_s,
   input  logic              req0_dir,
   input  logic              req0_filler,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [WIDTH-1:0]  req1_din,
   input  logic [SWIDTH-1:0] req1_s,
   input  logic              req1_dir,
   input  logic              req1_filler,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [WIDTH-1:0]  rsp_dout,
   output logic              rsp_sticky
);
   logic              last;
   logic              accept_p0;
   logic              grant0_p0, grant1_p0;
   logic              xfer0_p0, xfer1_p0, xfer_p0;
   logic [WIDTH-1:0]  din_p0;
   logic [SWIDTH-1:0] s_p0;
   logic              dir_p0, filler_p0;
   logic [WIDTH-1:0]  rdout_p0, ldout_p0, dout_p0;
   logic              rsticky_p0, lsticky_p0, sticky_p0;

   // Stage p0: arbitration, operand mux and shared shifters
   assign accept_p0 = ~rsp_valid | rsp_ready;
   assign grant0_p0 = req0_valid & (~req1_valid | last);
   assign grant1_p0 = req1_valid & (~req0_valid | ~last);

   assign req0_ready = accept_p0 & grant0_p0 & ~rst;
   assign req1_ready = accept_p0 & grant1_p0 & ~rst;

   assign xfer0_p0 = req0_valid & req0_ready;
   assign xfer1_p0 = req1_valid & req1_ready;
   assign xfer_p0  = xfer0_p0 | xfer1_p0;

   assign din_p0    = grant1_p0 ? req1_din    : req0_din;
   assign s_p0      = grant1_p0 ? req1_s      : req0_s;
   assign dir_p0    = grant1_p0 ? req1_dir    : req0_dir;
   assign filler_p0 = grant1_p0 ? req1_filler : req0_filler;

   bsr #(.WIDTH(WIDTH), .SWIDTH(SWIDTH)) u_bsr (
      .din    (din_p0),
      .s      (s_p0),
      .filler (filler_p0),
      .dout   (rdout_p0),
      .sticky (rsticky_p0)
   );

   bsl #(.WIDTH(WIDTH), .SWIDTH(SWIDTH)) u_bsl (
      .din    (din_p0),
      .s      (s_p0),
      .filler (filler_p0),
      .dout   (ldout_p0),
      .sticky (lsticky_p0)
   );

   assign dout_p0   = dir_p0 ? ldout_p0   : rdout_p0;
   assign sticky_p0 = dir_p0 ? lsticky_p0 : rsticky_p0;

   // Stage p1: response register; last only moves on an actual transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_dout   <= '0;
         rsp_sticky <= 1'b0;
         last       <= 1'b1;
      end else if (xfer_p0) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= xfer1_p0;
         rsp_dout   <= dout_p0;
         rsp_sticky <= sticky_p0;
         last       <= xfer1_p0;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fpu_shift_arb.sv
// Scoreboard bench for fpu_shift_arb: directed requests push expected
// results; an independent monitor pops and checks each presented result.

module tb_fpu_shift_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_dir, req0_filler;
   logic [31:0] req0_din;
   logic [4:0]  req0_s;
   logic        req1_valid, req1_ready, req1_dir, req1_filler;
   logic [31:0] req1_din;
   logic [4:0]  req1_s;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_sticky;
   logic [31:0] rsp_dout;

   typedef struct {
      logic        id;
      logic [31:0] dout;
      logic        st;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic        r0, r1;
   logic [31:0] e0_dout, e1_dout;
   logic        e0_st, e1_st;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fpu_shift_arb #(.WIDTH(32), .SWIDTH(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_din    (req0_din),
      .req0_s      (req0_s),
      .req0_dir    (req0_dir),
      .req0_filler (req0_filler),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_din    (req1_din),
      .req1_s      (req1_s),
      .req1_dir    (req1_dir),
      .req1_filler (req1_filler),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_dout    (rsp_dout),
      .rsp_sticky  (rsp_sticky)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic set_req(input int p, input logic [31:0] d, input logic [4:0] s,
                          input logic dir, input logic fill,
                          input logic [31:0] ed, input logic es);
      if (p == 0) begin
         req0_din = d; req0_s = s; req0_dir = dir; req0_filler = fill;
         e0_dout = ed; e0_st = es;
      end else begin
         req1_din = d; req1_s = s; req1_dir = dir; req1_filler = fill;
         e1_dout = ed; e1_st = es;
      end
   endtask

   // One clock: sample readies mid-cycle, record expected results for transfers.
   task automatic step();
      exp_t e;
      @(negedge clk);
      r0 = req0_ready;
      r1 = req1_ready;
      if (req0_valid && req0_ready) begin
         e.id = 1'b0; e.dout = e0_dout; e.st = e0_st; e.cyc = cyc + 1;
         sb.push_back(e);
      end
      if (req1_valid && req1_ready) begin
         e.id = 1'b1; e.dout = e1_dout; e.st = e1_st; e.cyc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic one(input int p, input logic [31:0] d, input logic [4:0] s,
                      input logic dir, input logic fill,
                      input logic [31:0] ed, input logic es);
      set_req(p, d, s, dir, fill, ed, es);
      if (p == 0) req0_valid = 1'b1; else req1_valid = 1'b1;
      step();
      chk("single_ready", (p == 0) ? r0 : r1, 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   // Monitor: a result is new when the previous cycle left the register free.
   initial begin
      exp_t        e;
      logic        prev_ok = 1'b1;
      logic [33:0] held = '0;
      forever begin
         @(negedge clk);
         chk("ready_without_valid", {req0_ready & ~req0_valid, req1_ready & ~req1_valid}, 0);
         if (rst) begin
            prev_ok = 1'b1;
         end else begin
            if (rsp_valid && prev_ok) begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_rsp: got id=%0d dout=0x%08h, expected no result", rsp_id, rsp_dout);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_id", rsp_id, e.id);
                  chk("rsp_dout", rsp_dout, e.dout);
                  chk("rsp_sticky", rsp_sticky, e.st);
                  chk("rsp_latency_cycle", cyc, e.cyc);
               end
               held = {rsp_id, rsp_sticky, rsp_dout};
            end else if (rsp_valid) begin
               chk("rsp_hold_stable", {rsp_id, rsp_sticky, rsp_dout}, held);
            end
            prev_ok = !rsp_valid || rsp_ready;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      set_req(0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
      set_req(1, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);

      // Reset: readies held low even with a request pending
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      step();
      chk("rst_req0_ready", r0, 0);
      chk("rst_req1_ready", r1, 0);
      step();
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_dout", rsp_dout, 0);
      chk("rst_rsp_sticky", rsp_sticky, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b0;

      // Contention from reset: grants 0,1,0,1,0,1 back-to-back
      set_req(0, 32'hDEADBEEF, 5'd4, 1'b0, 1'b0, 32'h0DEADBEE, 1'b1);
      set_req(1, 32'hDEADBEEF, 5'd4, 1'b1, 1'b0, 32'hEADBEEF0, 1'b1);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("contend_req0_ready", r0, (i % 2 == 0) ? 1 : 0);
         chk("contend_req1_ready", r1, (i % 2 == 1) ? 1 : 0);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Single-port directed vectors
      one(0, 32'hDEADBEEF, 5'd4,  1'b0, 1'b0, 32'h0DEADBEE, 1'b1);
      one(0, 32'hDEADBEEF, 5'd0,  1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
      one(1, 32'hDEADBEEF, 5'd4,  1'b1, 1'b0, 32'hEADBEEF0, 1'b1);
      one(1, 32'hDEADBEEF, 5'd31, 1'b1, 1'b0, 32'h80000000, 1'b1);
      one(0, 32'hDEADBEEF, 5'd8,  1'b0, 1'b1, 32'hFFDEADBE, 1'b1);
      one(0, 32'hDEADBEEF, 5'd31, 1'b0, 1'b0, 32'h00000001, 1'b1);
      one(1, 32'hDEADBEEF, 5'd8,  1'b1, 1'b1, 32'hADBEEFFF, 1'b1);
      one(1, 32'h00000001, 5'd0,  1'b1, 1'b1, 32'h00000001, 1'b0);
      one(0, 32'h00000002, 5'd1,  1'b0, 1'b0, 32'h00000001, 1'b0);
      step();

      // Backpressure: last grant was port 0, so port 1 wins, then port 0
      set_req(0, 32'h12345678, 5'd12, 1'b0, 1'b0, 32'h00012345, 1'b1);
      set_req(1, 32'h0000F000, 5'd16, 1'b1, 1'b0, 32'hF0000000, 1'b0);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      step();
      chk("bp_first_grant1", r1, 1);
      chk("bp_first_grant0", r0, 0);
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_req0_ready", r0, 0);
         chk("bp_req1_ready", r1, 0);
      end
      rsp_ready = 1'b1;
      step();
      chk("bp_release_grant0", r0, 1);
      chk("bp_release_grant1", r1, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      step();

      // Reset mid-operation with a held result and both requests pending
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      step();
      rst = 1'b1;
      rsp_ready = 1'b0;
      step();
      chk("midrst_req0_ready", r0, 0);
      chk("midrst_req1_ready", r1, 0);
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_rsp_id", rsp_id, 0);
      chk("midrst_rsp_dout", rsp_dout, 0);
      chk("midrst_rsp_sticky", rsp_sticky, 0);
      rst = 1'b0;
      sb.delete();
      rsp_ready = 1'b1;
      step();
      chk("postrst_grant0", r0, 1);
      chk("postrst_no_grant1", r1, 0);
      step();
      chk("postrst_grant1", r1, 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      step();
      chk("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fpu_shift_arb.md
# fpu_shift_arb

Shared-shifter arbiter for the FPU datapath. Two requesters, the add/sub alignment stage (port 0) and the post-add normalization stage (port 1), share one instance each of `bsr` and `bsl`, instantiated inside this block. The block arbitrates round-robin, configures the shifter (direction, amount, filler) and registers the result, the sticky bit and the requester ID. The result is returned through a single valid/ready response channel with backpressure.

## Interface
- `WIDTH`, 32: data width of operand and result.
- `SWIDTH`, 5: shift-amount width; passed to `bsr`/`bsl`. `2**SWIDTH >= WIDTH` is required.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_din`, `req1_din`  in  WIDTH  operand.
- `req0_s`, `req1_s`  in  SWIDTH  shift amount.
- `req0_dir`, `req1_dir`  in  1  0 = right (`bsr`), 1 = left (`bsl`).
- `req0_filler`, `req1_filler`  in  1  bit shifted in at the vacated positions.
- `rsp_valid`  out  1  result register holds a valid result.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_id`  out  1  requester that issued the result.
- `rsp_dout`  out  WIDTH  shifted result.
- `rsp_sticky`  out  1  OR of all `din` bits shifted out.

## Operation
- **Shifter sharing.**
  - A single `bsr` and a single `bsl` are fed from the operand mux selected by the grant.
  - `rsp_dout` takes the `bsr` output when `dir` = 0 and the `bsl` output when `dir` = 1.
- **Sticky bit.**
  - Right shift: sticky = OR of `din[s-1:0]`.
  - Left shift: sticky = OR of `din[WIDTH-1:WIDTH-s]`.
  - `s` = 0 gives sticky = 0.
  - `s >= WIDTH` (possible when `2**SWIDTH > WIDTH`): dout = all filler bits, sticky = OR of all of `din`.
- **Accept condition.** accept = !`rsp_valid` | `rsp_ready`. The output register is either empty or being drained in the same cycle.
- **Arbitration state.** The state is one bit, `last`, holding the ID of the most recent grant. Its reset value is 1, so port 0 wins the first contention.
  - Only one port valid: that port is granted.
  - Both ports valid: the port != `last` is granted.
  - Neither valid: no grant, and `last` is unchanged.
- **Ready and transfer.**
  - `reqN_ready` = accept & grant_N.
  - A transfer occurs when `reqN_valid` & `reqN_ready`.
  - On a transfer, `last` <= N.
  - `reqN_ready` depends on the valid inputs; this combinational path is permitted. `reqN_ready` must never be 1 while `reqN_valid` = 0.
- **Output register.**
  - On a transfer it loads `rsp_dout`, `rsp_sticky` and `rsp_id`, and sets `rsp_valid` = 1.
  - On `rsp_ready` with no transfer, `rsp_valid` <= 0.
  - While `rsp_valid` & !`rsp_ready`, all `rsp_*` outputs hold stable and both ready outputs are 0.
- **Requester obligation.** Each requester must hold its request stable while valid & !ready. The arbiter does not latch unaccepted requests.

## Timing
- **Latency.** Request accepted at cycle T; `rsp_valid` = 1 with its data at T+1.
- **Throughput.** One result per cycle while `rsp_ready` = 1. Under sustained contention, grants alternate 0, 1, 0, 1, …
- **Simultaneous drain and accept.** Drain and accept in the same cycle produce no bubble: the new result replaces the old one at the edge.
- **Reset.** `rst` = 1 at an edge forces:
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_dout` = 0, `rsp_sticky` = 0, `last` = 1.
  - Any held result is discarded, not delivered.
  - `req0_ready` = `req1_ready` = 0 throughout every cycle that `rst` is asserted.
  - First accept is possible in the cycle after `rst` deasserts.
- **Backpressure.** A requester granted under backpressure keeps its turn: `last` does not change until a transfer actually occurs.

## Test plan
- **Port 0 alone, right shift.** `din` = 0xDEADBEEF, `s` = 4, `dir` = 0, `filler` = 0 -> next cycle `rsp_dout` = 0x0DEADBEE, `sticky` = 1, `id` = 0. Then `s` = 0 -> 0xDEADBEEF, `sticky` = 0.
- **Port 1 alone, left shift.** `din` = 0xDEADBEEF, `s` = 4, `dir` = 1 -> `rsp_dout` = 0xEADBEEF0, `sticky` = 1, `id` = 1. Then `s` = 31 -> 0x80000000, `sticky` = 1.
- **Filler and extreme shift.** Right, `filler` = 1, `s` = 8 -> 0xFFDEADBE, `sticky` = 1. Right, `filler` = 0, `s` = 31 -> 0x00000001, `sticky` = 1.
- **Contention.**
  - Both ports valid for 6 cycles with `rsp_ready` = 1 -> `rsp_id` sequence 0, 1, 0, 1, 0, 1, back-to-back.
  - Each `reqN_ready` pulses on alternate cycles.
- **Backpressure.**
  - Hold `rsp_ready` = 0 for 3 cycles after the first result -> `rsp_*` stable, both ready outputs = 0, no grant and no `last` change.
  - Release -> the next grant goes to the other port when both are valid.
- **Reset mid-operation.** Assert `rst` while `rsp_valid` = 1 and both requests are pending -> next cycle all outputs are 0. After release, the first contended grant goes to port 0.
